fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side consumer for the dual-clock FIFO. It lives entirely in the read clock domain and watches the FIFO's `rempty` flag. Whenever it has buffer space, it pops the head word with `rinc` and loads it into a 2-entry output skid buffer. That buffer feeds a downstream valid/ready stream, so downstream back-pressure never causes the FIFO read side to lose or duplicate a word.

## Interface
Parameters:
- `width`, 8, data word width; must match the FIFO's `width`.
- `cnt_w`, 16, width of the delivered-word counter.

Ports:
- `rclk`  in  1  read-domain clock; all state updates on its rising edge.
- `rrst`  in  1  reset, synchronous to `rclk`, active-high.
- `enable`  in  1  drain enable; when low, no new words are popped and buffered words still drain.
- `rempty`  in  1  FIFO empty flag, already in the `rclk` domain.
- `rdata`  in  width  FIFO head word; valid combinationally whenever `rempty`=0.
- `rinc`  out  1  FIFO pop strobe; combinational.
- `m_data`  out  width  output word (head of skid buffer).
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts `m_data` this cycle.
- `word_cnt`  out  cnt_w  words delivered downstream since reset, wrapping.

## Operation
- Storage: 2-entry in-order buffer (entry0 = head driving `m_data`, entry1 = tail) plus occupancy `occ` in 0..2.
- `pop_out` = `m_valid` & `m_ready`.
- `rinc` = ~`rrst` & `enable` & ~`rempty` & (`occ`<2 | `pop_out`).
- `push` = `rinc`. On a push, `rdata` is captured at the same `rclk` edge.
- Occupancy update per edge:
  - `occ` += `push` − `pop_out`.
  - `m_valid` = (`occ` != 0), registered.
- Data movement:
  - push only, `occ`=0: word goes to entry0.
  - push only, `occ`=1: word goes to entry1.
  - pop only, `occ`=2: entry1 moves to entry0.
  - push+pop, `occ`=1: word goes to entry0.
  - push+pop, `occ`=2: entry1 moves to entry0 and the word goes to entry1.
  - Never push with `occ`=2 unless `pop_out`=1; this is guaranteed by the `rinc` equation.
- `m_data` holds its value while `m_valid`=1 and `m_ready`=0 (AXI-style stable hold). While `m_valid`=0, `m_data` holds its last value.
- `word_cnt` increments by 1 on every `pop_out`, modulo 2^cnt_w (0xFFFF → 0x0000 for `cnt_w`=16).
- `enable` falling: `rinc` drops in the same cycle; buffered words continue to drain. `enable` rising: popping resumes in the same cycle if `rempty`=0.
- Word order out equals FIFO order; no word is dropped or repeated.

## Timing
- Reset, when `rrst`=1 at an edge:
  - `occ`=0, `m_valid`=0, `m_data`=0, `word_cnt`=0.
  - `rinc`=0 for the whole cycle that `rrst` is high.
- Reset mid-operation: buffered words are discarded. FIFO pointers are untouched, so words already popped are lost and words still in the FIFO are delivered after reset releases.
- Latency: word popped in cycle t (`rinc`=1) appears with `m_valid`=1 in cycle t+1.
- Throughput: 1 word/cycle sustained while `rempty`=0 and `m_ready`=1.
- Full buffer (`occ`=2) with `m_ready`=0: `rinc`=0 regardless of `rempty`.
- Full buffer with `m_ready`=1: pop and push occur in the same cycle and `occ` stays 2.
- `rempty` asserting: `rinc`=0 that cycle; the buffer drains normally.
- `rinc` depends combinationally on `m_ready`. Downstream must not derive `m_ready` combinationally from `rinc`.

## Test plan
- Reset then idle:
  - Stimulus: assert `rrst` 2 cycles, then `rempty`=1, `m_ready`=1, `enable`=1.
  - Required: `m_valid`=0, `m_data`=0x00, `word_cnt`=0, `rinc`=0 throughout.
- Streaming:
  - Stimulus: FIFO preloaded with 0x11..0x18, `m_ready`=1.
  - Required: `rinc` high 8 consecutive cycles; `m_data` reads 0x11..0x18 in order, one per cycle starting 1 cycle after the first `rinc`; `word_cnt`=8.
- Back-pressure:
  - Stimulus: 4 words 0xA0..0xA3 available, `m_ready`=0 for 5 cycles, then 1.
  - Required: exactly 2 pops (`occ`=2); `m_data` held at 0xA0; `rinc`=0 while stalled; on release, output is 0xA0, 0xA1, 0xA2, 0xA3 with no gaps or duplicates.
- Full buffer with simultaneous push/pop:
  - Stimulus: `occ`=2, `m_ready`=1, `rempty`=0.
  - Required: `rinc`=1 and `occ` stays 2 each cycle; order preserved.
- Enable and empty toggling:
  - Stimulus: drop `enable` mid-stream.
  - Required: `rinc`=0 the same cycle and the buffered 2 words still drain.
  - Stimulus: let `rempty` go high.
  - Required: `m_valid` falls after the last buffered word.
- Counter wrap and mid-stream reset:
  - Stimulus: preset traffic until `word_cnt`=0xFFFF, then deliver one word.
  - Required: `word_cnt`=0x0000.
  - Stimulus: assert `rrst` with `occ`=2.
  - Required: next cycle `m_valid`=0, `occ`=0; after release, the next FIFO word is delivered first.

Source files
------------

// File: rtl/fifo_drain.sv
// fifo_drain: read-side consumer for the dual-clock FIFO.
// Pops into a 2-entry skid buffer that feeds a valid/ready stream.
module fifo_drain #(
  parameter int width = 8,
  parameter int cnt_w = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic             rempty,
  input  logic [width-1:0] rdata,
  output logic             rinc,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [cnt_w-1:0] word_cnt
);

  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic             pop_out;
  logic             push;
  logic             room;

  assign pop_out = m_valid & m_ready;
  // a full buffer may still take a word when its head leaves this cycle
  assign room    = (occ != 2'd2) | pop_out;
  assign rinc    = ~rrst & enable & ~rempty & room;
  assign push    = rinc;
  assign m_data  = head;

  // next occupancy from this cycle's push and pop
  always_comb begin
    occ_nxt = occ + 2'(push) - 2'(pop_out);
  end

  // buffer storage, occupancy, valid flag and delivered-word counter
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ      <= 2'd0;
      m_valid  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      word_cnt <= '0;
    end else begin
      occ     <= occ_nxt;
      m_valid <= (occ_nxt != 2'd0);
      if (pop_out) begin
        word_cnt <= word_cnt + 1'b1;
      end
      unique case (1'b1)
        (push & ~pop_out): begin
          if (occ == 2'd0) begin
            head <= rdata;
          end else begin
            tail <= rdata;
          end
        end
        (~push & pop_out): begin
          if (occ == 2'd2) begin
            head <= tail;
          end
        end
        (push & pop_out): begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= rdata;
          end else begin
            head <= rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed and random checks of fifo_drain
// against a queue-based model of the FIFO and the skid buffer.
module tb_fifo_drain;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          enable;
  logic          rempty;
  logic [W-1:0]  rdata;
  logic          rinc;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] word_cnt;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  buf_q[$];
  logic [W-1:0]  shown;
  logic [CW-1:0] cnt;
  logic [W-1:0]  exp_first;
  int            tests;
  int            fails;
  int            rinc_hits;

  always #5 rclk = ~rclk;

  fifo_drain #(.width(W), .cnt_w(CW)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .enable   (enable),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .word_cnt (word_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rempty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) rdata = fifo_q[0];
    else rdata = W'($urandom);
  endtask

  // one clock: settle inputs, check outputs, advance the model
  task automatic step(input bit check = 1'b1);
    bit pop;
    bit er;
    drive();
    #3;
    pop = (buf_q.size() > 0) && m_ready;
    er  = !rrst && enable && (fifo_q.size() > 0) &&
          ((buf_q.size() < 2) || pop);
    if (check) begin
      chk("rinc", rinc, er);
      chk("m_valid", m_valid, buf_q.size() > 0);
      chk("m_data", m_data, shown);
      chk("word_cnt", word_cnt, cnt);
    end
    if (rinc === 1'b1) rinc_hits++;
    @(posedge rclk);
    if (rrst) begin
      buf_q.delete();
      shown = '0;
      cnt   = '0;
    end else begin
      if (pop) begin
        void'(buf_q.pop_front());
        cnt++;
      end
      if (er) buf_q.push_back(fifo_q.pop_front());
      if (buf_q.size() > 0) shown = buf_q[0];
    end
    #1;
  endtask

  task automatic load(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
  endtask

  initial begin
    tests = 0; fails = 0; rinc_hits = 0;
    shown = '0; cnt = '0;
    rrst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    rempty = 1'b1; rdata = '0;

    // reset then idle
    step(1'b0);
    step();
    rrst = 1'b0;
    rinc_hits = 0;
    repeat (4) step();
    chk("idle_rinc", rinc_hits, 0);
    chk("idle_data", m_data, 8'h00);

    // streaming 0x11..0x18
    load(8'h11, 8);
    rinc_hits = 0;
    repeat (10) step();
    chk("stream_rinc", rinc_hits, 8);
    chk("stream_cnt", word_cnt, 16'd8);
    chk("stream_last", m_data, 8'h18);

    // back-pressure with 4 words waiting
    m_ready = 1'b0;
    load(8'hA0, 4);
    rinc_hits = 0;
    repeat (5) step();
    chk("bp_pops", rinc_hits, 2);
    chk("bp_hold", m_data, 8'hA0);
    chk("bp_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    repeat (6) step();
    chk("bp_cnt", word_cnt, 16'd12);
    chk("bp_last", m_data, 8'hA3);

    // full buffer with simultaneous push and pop
    m_ready = 1'b0;
    load(8'hB0, 6);
    repeat (3) step();
    m_ready = 1'b1;
    rinc_hits = 0;
    repeat (4) step();
    chk("full_rinc", rinc_hits, 4);
    repeat (4) step();
    chk("full_cnt", word_cnt, 16'd18);

    // enable drop mid-stream, buffered words still drain
    m_ready = 1'b0;
    load(8'hC0, 8);
    repeat (3) step();
    m_ready = 1'b1;
    enable = 1'b0;
    rinc_hits = 0;
    repeat (4) step();
    chk("en_off_rinc", rinc_hits, 0);
    chk("en_off_valid", m_valid, 1'b0);
    chk("en_off_data", m_data, 8'hC1);
    enable = 1'b1;
    repeat (9) step();
    chk("dry_valid", m_valid, 1'b0);
    chk("dry_data", m_data, 8'hC7);

    // counter wrap through 0xFFFF
    while (cnt != 16'hFFFF) begin
      if (fifo_q.size() < 4) fifo_q.push_back(W'($urandom));
      step();
    end
    if (fifo_q.size() < 4) fifo_q.push_back(W'($urandom));
    step();
    chk("wrap_cnt", word_cnt, 16'h0000);

    // reset with a full buffer
    repeat (6) step();
    m_ready = 1'b0;
    fifo_q.delete();
    repeat (3) step();
    load(8'hD0, 6);
    repeat (3) step();
    chk("pre_rst_valid", m_valid, 1'b1);
    rrst = 1'b1;
    step();
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_cnt", word_cnt, 16'h0000);
    exp_first = fifo_q[0];
    rrst = 1'b0;
    m_ready = 1'b1;
    step();
    chk("rst_first", m_data, exp_first);
    repeat (8) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(9) != 0);
      m_ready = ($urandom_range(2) != 0);
      rrst    = ($urandom_range(99) == 0);
      if ($urandom_range(3) != 0 && fifo_q.size() < 8)
        fifo_q.push_back(W'($urandom));
      step();
    end
    rrst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    repeat (16) step();
    chk("final_valid", m_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
